hamming_secded_decoder: RTL

// Streaming, parametrised Hamming SECDED decoder: single-error correct, double-error detect.

---
 rtl/hamming_pkg.sv | 35 +++
 rtl/hamming_secded_decoder_if.sv | 42 ++++
 rtl/hamming_secded_decoder_syndrome.sv | 33 +++
 rtl/hamming_secded_decoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// ============================================================================
// Module      : hamming_pkg
// Description : Shared helpers and types for the Hamming SECDED decoder family
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_pkg;

  // Widest error-position field carried in the status struct. It covers
  // codewords up to 255 bits; each decoder slices off the bits it needs.
  localparam int HSD_EP_W = 8;

  typedef struct packed {
    logic                corr;
    logic                uncorr;
    logic [HSD_EP_W-1:0] err_pos;
  } hsd_status_t;

  // Smallest r with 2**r >= data_w + r + 1
  function automatic int calc_r(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  // Hamming parity bits live at power-of-two positions
  function automatic logic is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_secded_decoder_if.sv
// ============================================================================
// Module      : hamming_secded_decoder_if
// Description : Codeword-in / result-out valid-ready bundle for the decoder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hamming_secded_decoder_if
  import hamming_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int R      = calc_r(DATA_W)
);
  localparam int CW_W = DATA_W + R + 1;
  localparam int EP_W = $clog2(CW_W + 1);

  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw;
  logic              correct_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_corr;
  logic              out_uncorr;
  logic [EP_W-1:0]   out_err_pos;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, in_cw, correct_en, out_ready,
    input  in_ready, out_valid, out_data, out_corr, out_uncorr, out_err_pos
  );

  // Decoder side
  modport slave (
    input  in_valid, in_cw, correct_en, out_ready,
    output in_ready, out_valid, out_data, out_corr, out_uncorr, out_err_pos
  );

endinterface

`default_nettype wire

// File: rtl/hamming_secded_decoder_syndrome.sv
// ============================================================================
// Module      : hamming_syndrome
// Description : Combinational Hamming syndrome and overall parity of a codeword
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int R      = calc_r(DATA_W)
) (
  input  wire logic [DATA_W+R:0] i_cw,
  output logic      [R-1:0]      o_syn,
  output logic                   o_op
);
  localparam int N = DATA_W + R;

  // Syndrome bit k checks every position whose index has bit k set
  always_comb begin
    o_syn = '0;
    for (int p = 1; p <= N; p++) begin
      for (int k = 0; k < R; k++) begin
        if (p[k]) o_syn[k] = o_syn[k] ^ i_cw[p-1];
      end
    end
    o_op = ^i_cw;
  end

endmodule

`default_nettype wire

// File: rtl/hamming_secded_decoder.sv
// ============================================================================
// Module      : hamming_secded_decoder
// Description : Two-stage streaming SECDED decoder with backpressure,
//               detect-only mode and saturating error counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int R      = calc_r(DATA_W),
  parameter int CNT_W  = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  hamming_secded_decoder_if.slave bus,
  input  wire logic             clr_counts,
  output logic [CNT_W-1:0]      corr_count,
  output logic [CNT_W-1:0]      uncorr_count
);
  localparam int N    = DATA_W + R;
  localparam int CW_W = N + 1;
  localparam int EP_W = $clog2(CW_W + 1);

  logic [R-1:0]      w_syn;
  logic              w_op;
  logic              w_s1_load;
  logic              w_s1_adv;
  logic              w_s2_load;
  logic              w_in_acc;
  logic              w_out_hs;
  logic [CW_W-1:0]   w_fix;
  logic [DATA_W-1:0] w_data;
  hsd_status_t       w_stat;

  logic              r_s1_full;
  logic [CW_W-1:0]   r_s1_cw;
  logic [R-1:0]      r_s1_syn;
  logic              r_s1_op;
  logic              r_s1_cen;

  logic              r_s2_full;
  logic [DATA_W-1:0] r_s2_data;
  hsd_status_t       r_s2_stat;

  logic [CNT_W-1:0]  r_corr_cnt;
  logic [CNT_W-1:0]  r_uncorr_cnt;

  hamming_syndrome #(.DATA_W(DATA_W), .R(R)) u_syndrome (
    .i_cw  (bus.in_cw),
    .o_syn (w_syn),
    .o_op  (w_op)
  );

  // A stage loads when empty or when its current word moves on this cycle
  assign w_s2_load    = !r_s2_full || bus.out_ready;
  assign w_s1_adv     = r_s1_full && w_s2_load;
  assign w_s1_load    = !r_s1_full || w_s1_adv;
  assign w_in_acc     = bus.in_valid && w_s1_load;
  assign w_out_hs     = r_s2_full && bus.out_ready;
  assign bus.in_ready = w_s1_load;

  // Classify the S1 word and flip the located bit when correction is enabled
  always_comb begin
    w_stat = '0;
    w_fix  = r_s1_cw;
    if (r_s1_syn == '0) begin
      if (r_s1_op) begin
        // Only the overall parity bit is wrong; data needs no change
        w_stat.corr    = 1'b1;
        w_stat.err_pos = HSD_EP_W'(CW_W);
      end
    end else if (r_s1_op && (int'(r_s1_syn) <= N)) begin
      w_stat.corr    = 1'b1;
      w_stat.err_pos = HSD_EP_W'(r_s1_syn);
      for (int p = 1; p <= N; p++) begin
        if (r_s1_cen && (int'(r_s1_syn) == p)) w_fix[p-1] = ~r_s1_cw[p-1];
      end
    end else begin
      // Even-weight error, or a syndrome pointing past the codeword
      w_stat.uncorr = 1'b1;
    end
  end

  // Pull data bits out of the non-power-of-two positions, LSB first
  always_comb begin : p_extract
    int j;
    j      = 0;
    w_data = '0;
    for (int p = 1; p <= N; p++) begin
      if (!is_pow2(p)) begin
        w_data[j] = w_fix[p-1];
        j++;
      end
    end
  end

  // Stage 1: capture the codeword with its syndrome, parity and mode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_full <= 1'b0;
      r_s1_cw   <= '0;
      r_s1_syn  <= '0;
      r_s1_op   <= 1'b0;
      r_s1_cen  <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_full <= w_in_acc;
      if (w_in_acc) begin
        r_s1_cw  <= bus.in_cw;
        r_s1_syn <= w_syn;
        r_s1_op  <= w_op;
        r_s1_cen <= bus.correct_en;
      end
    end
  end

  // Stage 2: hold the decoded result until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_full <= 1'b0;
      r_s2_data <= '0;
      r_s2_stat <= '0;
    end else if (w_s2_load) begin
      r_s2_full <= r_s1_full;
      if (r_s1_full) begin
        r_s2_data <= w_data;
        r_s2_stat <= w_stat;
      end
    end
  end

  // Saturating counters, stepped only when a result is handed over
  always_ff @(posedge clk) begin
    if (rst || clr_counts) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_s2_stat.corr && (r_corr_cnt != '1))
        r_corr_cnt <= r_corr_cnt + CNT_W'(1);
      if (r_s2_stat.uncorr && (r_uncorr_cnt != '1))
        r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid   = r_s2_full;
  assign bus.out_data    = r_s2_data;
  assign bus.out_corr    = r_s2_stat.corr;
  assign bus.out_uncorr  = r_s2_stat.uncorr;
  assign bus.out_err_pos = r_s2_stat.err_pos[EP_W-1:0];
  assign corr_count      = r_corr_cnt;
  assign uncorr_count    = r_uncorr_cnt;

endmodule

`default_nettype wire
